// File: rtl/alu_sweep_gen_pkg.sv
// ============================================================================
// Module : alu_sweep_gen_pkg
// Brief  : ALU operation codes, flag indices and sweep FSM encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_sweep_gen_pkg;

  localparam int C_ALU_OPER_WIDTH  = 4;
  localparam int C_ALU_NUM_OPERS   = 13;
  localparam int C_PROC_FLAG_WIDTH = 4;

  typedef enum logic [C_ALU_OPER_WIDTH-1:0] {
    OPER_ADD = 4'd0,
    OPER_ADC = 4'd1,
    OPER_SUB = 4'd2,
    OPER_SBC = 4'd3,
    OPER_AND = 4'd4,
    OPER_OR  = 4'd5,
    OPER_XOR = 4'd6,
    OPER_NOT = 4'd7,
    OPER_LSL = 4'd8,
    OPER_LSR = 4'd9,
    OPER_ASR = 4'd10,
    OPER_ROL = 4'd11,
    OPER_ROR = 4'd12
  } alu_oper_e;

  localparam int C_FLAG_C = 0;
  localparam int C_FLAG_Z = 1;
  localparam int C_FLAG_N = 2;
  localparam int C_FLAG_V = 3;

  // Operations that consume carry-in and therefore sweep it as an extra vector bit.
  localparam logic [C_ALU_NUM_OPERS-1:0] C_ALU_CARRY_OPER_MASK =
    (C_ALU_NUM_OPERS'(1) << OPER_ADC) | (C_ALU_NUM_OPERS'(1) << OPER_SBC);

  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_SWEEP = 2'd1;
  localparam logic [1:0] C_ST_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/alu_sweep_gen_sig_misr.sv
// ============================================================================
// Module : sig_misr
// Brief  : Multiple-input signature register compacting one data word per enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sig_misr #(
  parameter int                   SIG_WIDTH = 16,
  parameter logic [SIG_WIDTH-1:0] SIG_POLY  = 16'h1021,
  parameter logic [SIG_WIDTH-1:0] SIG_SEED  = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [SIG_WIDTH-1:0] din,
  output logic [SIG_WIDTH-1:0] sig
);

  logic [SIG_WIDTH-1:0] r_sig;
  logic [SIG_WIDTH-1:0] w_sig_next;

  always_comb begin
    w_sig_next = {r_sig[SIG_WIDTH-2:0], 1'b0}
               ^ (r_sig[SIG_WIDTH-1] ? SIG_POLY : '0)
               ^ din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= SIG_SEED;
    end else if (clear) begin
      r_sig <= SIG_SEED;
    end else if (enable) begin
      r_sig <= w_sig_next;
    end
  end

  assign sig = r_sig;

endmodule

`default_nettype wire

// File: rtl/alu_sweep_gen.sv
// ============================================================================
// Module : alu_sweep_gen
// Brief  : Exhaustive ALU stimulus sweeper with MISR result compaction.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_sweep_gen
  import alu_sweep_gen_pkg::*;
#(
  parameter int                   DATA_WIDTH      = 8,
  parameter int                   B_SWEEP_BITS    = 2,
  parameter int                   OPER_WIDTH      = C_ALU_OPER_WIDTH,
  parameter int                   NUM_OPERS       = C_ALU_NUM_OPERS,
  parameter logic [NUM_OPERS-1:0] CARRY_OPER_MASK = NUM_OPERS'(C_ALU_CARRY_OPER_MASK),
  parameter int                   FLAG_WIDTH      = C_PROC_FLAG_WIDTH,
  parameter int                   CARRY_BIT       = C_FLAG_C,
  parameter int                   SIG_WIDTH       = 16,
  parameter logic [SIG_WIDTH-1:0] SIG_POLY        = 16'h1021,
  parameter logic [SIG_WIDTH-1:0] SIG_SEED        = 16'hFFFF,
  parameter int                   CNT_WIDTH       = 32
) (
  input  logic                  master_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_OPERS-1:0]  oper_mask,
  output logic [OPER_WIDTH-1:0] alu_oper,
  output logic [DATA_WIDTH-1:0] alu_a_in,
  output logic [DATA_WIDTH-1:0] alu_b_in,
  output logic [FLAG_WIDTH-1:0] alu_flags_in,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic [FLAG_WIDTH-1:0] alu_flags_out,
  output logic                  busy,
  output logic                  done,
  output logic [SIG_WIDTH-1:0]  signature,
  output logic [CNT_WIDTH-1:0]  vec_count
);

  localparam int C_VEC_W = DATA_WIDTH + B_SWEEP_BITS + 1;

  logic [1:0]              r_state;
  logic [1:0]              w_state_next;
  logic [NUM_OPERS-1:0]    r_remaining;
  logic [OPER_WIDTH-1:0]   r_oper;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [B_SWEEP_BITS-1:0] r_b_lo;
  logic                    r_c;
  logic [CNT_WIDTH-1:0]    r_vec_count;

  logic                    w_accept;
  logic                    w_advance;
  logic                    w_carry_en;
  logic [C_VEC_W-1:0]      w_vec;
  logic [C_VEC_W-1:0]      w_vec_inc;
  logic                    w_vec_last;
  logic [DATA_WIDTH-1:0]   w_a_next;
  logic [B_SWEEP_BITS-1:0] w_b_next;
  logic                    w_c_next;
  logic [NUM_OPERS-1:0]    w_rem_after;
  logic [NUM_OPERS-1:0]    w_pick_src;
  logic                    w_pick_any;
  logic [OPER_WIDTH-1:0]   w_pick_idx;

  assign w_accept  = start && !abort && ((r_state == C_ST_IDLE) || (r_state == C_ST_DONE));
  assign w_advance = (r_state == C_ST_SWEEP) && !abort;

  // Vector counter is {a, b_lo, c}; non-carry opers drop c and count {a, b_lo}.
  always_comb begin
    w_carry_en = 1'b0;
    for (int i = 0; i < NUM_OPERS; i++) begin
      if (r_oper == OPER_WIDTH'(i)) w_carry_en = CARRY_OPER_MASK[i];
    end
    w_vec      = w_carry_en ? {r_a, r_b_lo, r_c} : {1'b0, r_a, r_b_lo};
    w_vec_last = w_carry_en ? (&w_vec) : (&w_vec[C_VEC_W-2:0]);
    w_vec_inc  = w_vec + C_VEC_W'(1);
    if (w_carry_en) begin
      w_a_next = w_vec_inc[C_VEC_W-1 -: DATA_WIDTH];
      w_b_next = w_vec_inc[B_SWEEP_BITS:1];
      w_c_next = w_vec_inc[0];
    end else begin
      w_a_next = w_vec_inc[C_VEC_W-2 -: DATA_WIDTH];
      w_b_next = w_vec_inc[B_SWEEP_BITS-1:0];
      w_c_next = 1'b0;
    end
  end

  // Lowest-set-bit finder: the start mask on acceptance, else what remains after this oper.
  always_comb begin
    for (int i = 0; i < NUM_OPERS; i++) begin
      w_rem_after[i] = r_remaining[i] && (r_oper != OPER_WIDTH'(i));
    end
    w_pick_src = (r_state == C_ST_SWEEP) ? w_rem_after : oper_mask;
    w_pick_any = |w_pick_src;
    w_pick_idx = '0;
    for (int i = NUM_OPERS - 1; i >= 0; i--) begin
      if (w_pick_src[i]) w_pick_idx = OPER_WIDTH'(i);
    end
  end

  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = C_ST_IDLE;
    end else begin
      case (r_state)
        C_ST_IDLE, C_ST_DONE: begin
          if (start) w_state_next = w_pick_any ? C_ST_SWEEP : C_ST_DONE;
        end
        C_ST_SWEEP: begin
          if (w_vec_last && !w_pick_any) w_state_next = C_ST_DONE;
        end
        default: w_state_next = C_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == C_ST_SWEEP);
    done = (r_state == C_ST_DONE);
  end

  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= '0;
      r_oper      <= '0;
      r_a         <= '0;
      r_b_lo      <= '0;
      r_c         <= 1'b0;
      r_vec_count <= '0;
    end else if (w_accept) begin
      r_remaining <= oper_mask;
      r_vec_count <= '0;
      if (w_pick_any) begin
        r_oper <= w_pick_idx;
        r_a    <= '0;
        r_b_lo <= '0;
        r_c    <= 1'b0;
      end
    end else if (w_advance) begin
      if (r_vec_count != '1) r_vec_count <= r_vec_count + CNT_WIDTH'(1);
      if (w_vec_last) begin
        r_remaining <= w_rem_after;
        // With nothing left the last vector stays on the ALU inputs.
        if (w_pick_any) begin
          r_oper <= w_pick_idx;
          r_a    <= '0;
          r_b_lo <= '0;
          r_c    <= 1'b0;
        end
      end else begin
        r_a    <= w_a_next;
        r_b_lo <= w_b_next;
        r_c    <= w_c_next;
      end
    end
  end

  assign alu_oper  = r_oper;
  assign alu_a_in  = r_a;
  assign alu_b_in  = DATA_WIDTH'(r_b_lo);
  assign vec_count = r_vec_count;

  for (genvar g = 0; g < FLAG_WIDTH; g++) begin : g_flags_in
    if (g == CARRY_BIT) begin : g_carry
      assign alu_flags_in[g] = r_c;
    end else begin : g_zero
      assign alu_flags_in[g] = 1'b0;
    end
  end

  sig_misr #(
    .SIG_WIDTH (SIG_WIDTH),
    .SIG_POLY  (SIG_POLY),
    .SIG_SEED  (SIG_SEED)
  ) u_sig_misr (
    .clk    (master_clk),
    .rst_n  (rst_n),
    .clear  (w_accept),
    .enable (w_advance),
    .din    (SIG_WIDTH'({alu_flags_out, alu_out})),
    .sig    (signature)
  );

endmodule

`default_nettype wire

// File: tb/tb_alu_sweep_gen.sv
// ============================================================================
// Module : tb_alu_sweep_gen
// Brief  : Directed bench for alu_sweep_gen driving a small 2-bit reference ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_sweep_gen;
  import alu_sweep_gen_pkg::*;

  localparam int DW = 2;
  localparam int NO = 13;
  localparam logic [NO-1:0] C_CARRY = 13'h00A;
  localparam logic [NO-1:0] M_LSL   = 13'h100;
  localparam logic [NO-1:0] M_ADC   = 13'h002;

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    fl;
  } vec_t;

  logic          master_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NO-1:0] oper_mask = '0;
  logic [3:0]    alu_oper;
  logic [DW-1:0] alu_a_in, alu_b_in, alu_out;
  logic [3:0]    alu_flags_in, alu_flags_out;
  logic          busy, done;
  logic [15:0]   signature;
  logic [31:0]   vec_count;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t exp_q[$];

  alu_sweep_gen #(
    .DATA_WIDTH(DW), .B_SWEEP_BITS(2), .OPER_WIDTH(4), .NUM_OPERS(NO),
    .CARRY_OPER_MASK(C_CARRY), .FLAG_WIDTH(4), .CARRY_BIT(0),
    .SIG_WIDTH(16), .SIG_POLY(16'h1021), .SIG_SEED(16'hFFFF), .CNT_WIDTH(32)
  ) dut (
    .master_clk(master_clk), .rst_n(rst_n), .start(start), .abort(abort),
    .oper_mask(oper_mask), .alu_oper(alu_oper), .alu_a_in(alu_a_in),
    .alu_b_in(alu_b_in), .alu_flags_in(alu_flags_in), .alu_out(alu_out),
    .alu_flags_out(alu_flags_out), .busy(busy), .done(done),
    .signature(signature), .vec_count(vec_count)
  );

  always #5 master_clk = ~master_clk;

  // Reference ALU; flags are {V, N, Z, C}.
  function automatic logic [5:0] alu_ref(input logic [3:0] op, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b, input logic [3:0] fin);
    logic [2:0] s;
    logic       v;
    s = '0;
    v = 1'b0;
    case (op)
      OPER_ADD: s = {1'b0, a} + {1'b0, b};
      OPER_ADC: begin
        s = {1'b0, a} + {1'b0, b} + {2'b00, fin[0]};
        v = (a[1] == b[1]) && (s[1] != a[1]);
      end
      OPER_SUB: s = {1'b0, a} - {1'b0, b};
      OPER_AND: s = {1'b0, a & b};
      OPER_OR:  s = {1'b0, a | b};
      OPER_XOR: s = {1'b0, a ^ b};
      OPER_LSL: s = {1'b0, a} << b;
      default:  s = {1'b0, a};
    endcase
    return {v, s[1], (s[1:0] == 2'b00), s[2], s[1:0]};
  endfunction

  always_comb {alu_flags_out, alu_out} = alu_ref(alu_oper, alu_a_in, alu_b_in, alu_flags_in);

  function automatic vec_t vec_of(input int op, input int i);
    vec_t       v;
    logic [4:0] k;
    k    = 5'(i);
    v.op = 4'(op);
    if (C_CARRY[op]) begin
      v.a = k[4:3]; v.b = k[2:1]; v.fl = {3'b000, k[0]};
    end else begin
      v.a = k[3:2]; v.b = k[1:0]; v.fl = 4'b0000;
    end
    return v;
  endfunction

  function automatic int vecs_per_op(input int op);
    return C_CARRY[op] ? 32 : 16;
  endfunction

  // Expected signature after the first nmax vectors of a sweep over mask.
  function automatic logic [15:0] model_sig(input logic [NO-1:0] mask, input int nmax);
    logic [15:0] s;
    logic [5:0]  d;
    vec_t        v;
    int          k;
    s = 16'hFFFF;
    k = 0;
    for (int op = 0; op < NO; op++) begin
      if (mask[op]) begin
        for (int i = 0; i < vecs_per_op(op); i++) begin
          if (k < nmax) begin
            v = vec_of(op, i);
            d = alu_ref(v.op, v.a, v.b, v.fl);
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {10'b0, d};
            k++;
          end
        end
      end
    end
    return s;
  endfunction

  task automatic push_sweep(input logic [NO-1:0] mask);
    for (int op = 0; op < NO; op++) begin
      if (mask[op]) begin
        for (int i = 0; i < vecs_per_op(op); i++) exp_q.push_back(vec_of(op, i));
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Starts a sweep and checks every driven vector against the scoreboard.
  task automatic run_sweep(input logic [NO-1:0] mask, input int abort_at,
                           input int poke_at, output int nb);
    vec_t v;
    nb = 0;
    @(negedge master_clk);
    oper_mask = mask;
    start     = 1'b1;
    @(negedge master_clk);
    start = 1'b0;
    repeat (200) begin
      if (!busy) break;
      if (exp_q.size() == 0) begin
        chk("queue_underrun", 32'(exp_q.size()), 32'd1);
      end else begin
        v = exp_q.pop_front();
        chk("vector", {20'b0, alu_oper, alu_a_in, alu_b_in, alu_flags_in},
            {20'b0, v.op, v.a, v.b, v.fl});
      end
      nb++;
      start = (nb == poke_at);
      if (nb == poke_at) oper_mask = 13'h1FFF;
      abort = (nb == abort_at);
      @(negedge master_clk);
    end
    start     = 1'b0;
    abort     = 1'b0;
    oper_mask = mask;
  endtask

  initial begin
    int          nb;
    logic [15:0] sig_adc;

    repeat (2) @(negedge master_clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sig", 32'(signature), 32'hFFFF);
    chk("reset_cnt", vec_count, 32'd0);
    chk("reset_alu", {20'b0, alu_oper, alu_a_in, alu_b_in, alu_flags_in}, 32'd0);
    rst_n = 1'b1;

    // Single non-carry operation.
    push_sweep(M_LSL);
    run_sweep(M_LSL, 0, 0, nb);
    chk("lsl_cycles", 32'(nb), 32'd16);
    chk("lsl_done", 32'(done), 32'd1);
    chk("lsl_cnt", vec_count, 32'd16);
    chk("lsl_sig", 32'(signature), 32'(model_sig(M_LSL, 1000)));
    chk("lsl_hold", {24'b0, alu_oper, alu_a_in, alu_b_in}, {24'b0, 4'd8, 2'd3, 2'd3});

    // Carry operation sweeps carry-in as the LSB.
    push_sweep(M_ADC);
    run_sweep(M_ADC, 0, 0, nb);
    sig_adc = signature;
    chk("adc_cycles", 32'(nb), 32'd32);
    chk("adc_cnt", vec_count, 32'd32);
    chk("adc_sig", 32'(signature), 32'(model_sig(M_ADC, 1000)));

    // Two operations back to back, with an ignored start mid-sweep.
    push_sweep(M_LSL | M_ADC);
    run_sweep(M_LSL | M_ADC, 0, 10, nb);
    chk("multi_cycles", 32'(nb), 32'd48);
    chk("multi_done", 32'(done), 32'd1);
    chk("multi_cnt", vec_count, 32'd48);
    chk("multi_sig", 32'(signature), 32'(model_sig(M_LSL | M_ADC, 1000)));
    chk("multi_queue", 32'(exp_q.size()), 32'd0);

    // Empty mask goes straight to DONE.
    run_sweep('0, 0, 0, nb);
    chk("empty_cycles", 32'(nb), 32'd0);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_cnt", vec_count, 32'd0);
    chk("empty_sig", 32'(signature), 32'hFFFF);

    // Abort after five vectors compacted, then a clean rerun.
    push_sweep(M_ADC);
    run_sweep(M_ADC, 6, 0, nb);
    exp_q.delete();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_cnt", vec_count, 32'd5);
    chk("abort_sig", 32'(signature), 32'(model_sig(M_ADC, 5)));
    push_sweep(M_ADC);
    run_sweep(M_ADC, 0, 0, nb);
    chk("rerun_sig", 32'(signature), 32'(sig_adc));
    chk("rerun_cnt", vec_count, 32'd32);

    // Asynchronous reset in the middle of a sweep.
    @(negedge master_clk);
    oper_mask = M_LSL;
    start     = 1'b1;
    @(negedge master_clk);
    start = 1'b0;
    repeat (3) @(negedge master_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sig", 32'(signature), 32'hFFFF);
    chk("midrst_cnt", vec_count, 32'd0);
    @(negedge master_clk);
    rst_n = 1'b1;
    @(negedge master_clk);
    chk("midrst_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
